computie_bus_ad_sequencer: RTL and testbench
============================================

COMPUTIE_BUS_AD_SEQUENCER -- requirements
Module: computie_bus_ad_sequencer

Interface
REQ-001 Parameter BITWIDTH, default 32: width of the multiplexed address/data pins and of all address/data ports.
REQ-002 Parameter ADDR_CYCLES, default 1, range 1..15: number of cycles the address is driven before the data phase.
REQ-003 Parameter TURNAROUND, default 1, range 1..7: number of dead cycles with no driver, used on read turnaround and on release.
REQ-004 Parameter TIMEOUT, default 255, range 1..65535: number of data-phase cycles without ack before the cycle is aborted.
REQ-005 Port clock, input, 1: single clock; all state changes occur on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port req_valid, input, 1: a request is presented.
REQ-008 Port req_ready, output, 1: the block accepts a request this cycle.
REQ-009 Port req_write, input, 1: 1 selects write, 0 selects read.
REQ-010 Port req_addr, input, BITWIDTH: address of the request.
REQ-011 Port req_wdata, input, BITWIDTH: write data.
REQ-012 Port resp_valid, output, 1: one-cycle completion pulse.
REQ-013 Port resp_error, output, 1: qualifies resp_valid; 1 means the cycle timed out.
REQ-014 Port resp_rdata, output, BITWIDTH: read data, valid while resp_valid is high.
REQ-015 Port ad_out, output, BITWIDTH: value driven onto the pins.
REQ-016 Port ad_oe, output, 1: pin output enable.
REQ-017 Port ad_in, input, BITWIDTH: sampled pin value.
REQ-018 Port bus_as, output, 1: address strobe, active-high.
REQ-019 Port bus_ds, output, 1: data strobe, active-high.
REQ-020 Port bus_write, output, 1: direction indicator to the target.
REQ-021 Port bus_ack, input, 1: asynchronous target acknowledge.

Function
REQ-022 bus_ack SHALL pass through a 2-flop synchronizer (ack_s); all decisions SHALL use ack_s only.
REQ-023 All outputs SHALL be registered; ad_oe and the strobes SHALL never glitch.
REQ-024 States SHALL be IDLE, ADDR, TURN, DATA and RELEASE.
REQ-025 IDLE: req_ready=1, ad_oe=0, bus_as=0, bus_ds=0; on req_valid, latch addr/wdata/write and go to ADDR.
REQ-026 ADDR: ad_oe=1, ad_out=addr, bus_as=1, bus_write=write, for exactly ADDR_CYCLES cycles; then go to DATA if write, or to TURN if read.
REQ-027 TURN (read only): ad_oe=0, bus_as=1, for exactly TURNAROUND cycles; then go to DATA.
REQ-028 DATA, write: ad_oe=1, ad_out=wdata, bus_as=1, bus_ds=1.
REQ-029 DATA, read: ad_oe=0, bus_as=1, bus_ds=1.
REQ-030 DATA exit on ack_s=1: for a read, capture ad_in into resp_rdata on that edge; then go to RELEASE with resp_error=0.
REQ-031 The DATA cycle counter SHALL start at 0 on entry; when it reaches TIMEOUT with ack_s=0, go to RELEASE with resp_error=1 and resp_rdata unchanged.
REQ-032 resp_valid SHALL be 1 for exactly the first cycle of RELEASE.
REQ-033 RELEASE: ad_oe=0, bus_as=0, bus_ds=0; stay until at least TURNAROUND cycles have elapsed AND ack_s=0; then go to IDLE.
REQ-034 req_ready SHALL be 0 in every state except IDLE; a request held during a busy cycle SHALL be accepted on the first IDLE cycle.
REQ-035 Back-to-back requests: with req_valid held, at most one request SHALL be accepted per IDLE visit; minimum spacing between accepts is 1+ADDR_CYCLES+1+TURNAROUND+1 cycles (write with immediate ack).
REQ-036 ad_oe SHALL be 0 for at least TURNAROUND cycles between the target driving (read DATA) and the block driving (next ADDR).
REQ-037 If ack_s is already 1 on DATA entry, the transfer SHALL complete after one DATA cycle.
REQ-038 All counters SHALL be sized to their parameter maximum and SHALL never wrap.

Reset
REQ-039 Reset SHALL act asynchronously from any state: state=IDLE; ad_oe=0, bus_as=0, bus_ds=0, bus_write=0, resp_valid=0, resp_error=0, ad_out=0, resp_rdata=0, synchronizer=0, counters=0.
REQ-040 A transaction interrupted by reset SHALL be dropped with no response; req_ready=1 on the first clock edge after reset deasserts.

Verification
REQ-041 Write (defaults), addr=0x00001000, wdata=0xDEADBEEF, ack raised in DATA -> 1 ADDR cycle showing 0x00001000, then DATA showing 0xDEADBEEF with ad_oe=1, resp_valid pulse with resp_error=0.
REQ-042 Read, addr=0x00002000, target drives 0x12345678 with ack -> ad_oe=0 during TURN and DATA, resp_rdata=0x12345678 during the resp_valid pulse.
REQ-043 Read with no ack, TIMEOUT=8 -> exit after 8 DATA cycles; resp_valid=1, resp_error=1, strobes drop.
REQ-044 Ack held high after completion -> block stays in RELEASE until ack_s=0; req_ready stays 0 with req_valid high.
REQ-045 Reset asserted mid-DATA of a write -> ad_oe, bus_as and bus_ds go 0 immediately with no clock; no resp_valid; IDLE after release.
REQ-046 ADDR_CYCLES=3, TURNAROUND=2, back-to-back read then write -> address held 3 cycles, 2 dead cycles in TURN and in RELEASE, and ad_oe=0 for ≥2 cycles before the write address.

Source files
------------

// File: rtl/computie_bus_ad_sequencer_if.sv
// Request/response handshake plus multiplexed address/data bus pins of the sequencer.
// master = the sequencer; slave = the requester/target environment.
interface computie_bus_ad_sequencer_if #(
  parameter int BITWIDTH = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_error;
  logic [BITWIDTH-1:0] resp_rdata;
  logic [BITWIDTH-1:0] ad_out;
  logic                ad_oe;
  logic [BITWIDTH-1:0] ad_in;
  logic                bus_as;
  logic                bus_ds;
  logic                bus_write;
  logic                bus_ack;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ad_in, bus_ack,
    output req_ready, resp_valid, resp_error, resp_rdata, ad_out, ad_oe,
           bus_as, bus_ds, bus_write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ad_in, bus_ack,
    input  req_ready, resp_valid, resp_error, resp_rdata, ad_out, ad_oe,
           bus_as, bus_ds, bus_write
  );
endinterface

// File: rtl/computie_bus_ad_sequencer.sv
// Multiplexed address/data bus master: address phase, optional read turnaround,
// data phase with ack/timeout, then a release phase before the next request.
module computie_bus_ad_sequencer #(
  parameter int BITWIDTH    = 32,
  parameter int ADDR_CYCLES = 1,
  parameter int TURNAROUND  = 1,
  parameter int TIMEOUT     = 255
) (
  input  logic                          clock,
  input  logic                          reset,
  computie_bus_ad_sequencer_if.master   bus
);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, RELEASE} state_t;

  // Wide enough for the largest TIMEOUT; every counter saturates instead of wrapping.
  localparam int CW = 16;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_CYCLES - 1);
  localparam logic [CW-1:0] TURN_LAST = CW'(TURNAROUND - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ack_m, ack_s;
  logic [BITWIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic                wr_q, wr_d;

  logic                ready_q, ready_d;
  logic                rv_q, rv_d;
  logic                err_q, err_d;
  logic [BITWIDTH-1:0] rdata_q, rdata_d;
  logic [BITWIDTH-1:0] ad_out_q, ad_out_d;
  logic                oe_q, oe_d;
  logic                as_q, as_d;
  logic                ds_q, ds_d;
  logic                bw_q, bw_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ack_m    <= 1'b0;
      ack_s    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      ready_q  <= 1'b1;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      ad_out_q <= '0;
      oe_q     <= 1'b0;
      as_q     <= 1'b0;
      ds_q     <= 1'b0;
      bw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_m    <= bus.bus_ack;
      ack_s    <= ack_m;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      ready_q  <= ready_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      ad_out_q <= ad_out_d;
      oe_q     <= oe_d;
      as_q     <= as_d;
      ds_q     <= ds_d;
      bw_q     <= bw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rv_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          wr_d    = bus.req_write;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cnt_q >= ADDR_LAST) begin
          cnt_d   = '0;
          state_d = wr_q ? DATA : TURN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TURN: begin
        if (cnt_q >= TURN_LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (ack_s) begin
          if (!wr_q) rdata_d = bus.ad_in;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else if (cnt_q >= DATA_LAST) begin
          err_d   = 1'b1;
          rv_d    = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Target must have dropped its ack before another cycle may start.
        if (cnt_q >= TURN_LAST && !ack_s) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q < TURN_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Pin controls are decoded from the next state so they register cleanly with it.
    ready_d  = (state_d == IDLE);
    oe_d     = (state_d == ADDR) || (state_d == DATA && wr_d);
    as_d     = (state_d == ADDR) || (state_d == TURN) || (state_d == DATA);
    ds_d     = (state_d == DATA);
    bw_d     = as_d && wr_d;
    ad_out_d = ad_out_q;
    if (state_d == ADDR)            ad_out_d = addr_d;
    else if (state_d == DATA && wr_d) ad_out_d = wdata_d;
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_error = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.ad_out     = ad_out_q;
  assign bus.ad_oe      = oe_q;
  assign bus.bus_as     = as_q;
  assign bus.bus_ds     = ds_q;
  assign bus.bus_write  = bw_q;

endmodule

// File: tb/tb_computie_bus_ad_sequencer.sv
// Directed bench: u0 has default timing with TIMEOUT=8, u1 has ADDR_CYCLES=3, TURNAROUND=2.
module tb_computie_bus_ad_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  computie_bus_ad_sequencer_if #(.BITWIDTH(32)) i0 ();
  computie_bus_ad_sequencer_if #(.BITWIDTH(32)) i1 ();

  computie_bus_ad_sequencer #(.BITWIDTH(32), .ADDR_CYCLES(1), .TURNAROUND(1), .TIMEOUT(8)) u0 (
    .clock(clock), .reset(reset), .bus(i0)
  );
  computie_bus_ad_sequencer #(.BITWIDTH(32), .ADDR_CYCLES(3), .TURNAROUND(2), .TIMEOUT(8)) u1 (
    .clock(clock), .reset(reset), .bus(i1)
  );

  // Returns cycles until u0 shows req_ready, or -1 if it never does.
  task automatic wait_idle0(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clock);
      if (i0.req_ready === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write, i0.resp_valid, i0.resp_error} !== 6'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write, i0.resp_valid, i0.resp_error}); end
    checks++;
    if (i0.ad_out !== 32'h0 || i0.resp_rdata !== 32'h0)
      begin errors++; $display("FAIL reset_data: ad_out=%h rdata=%h expected 0", i0.ad_out, i0.resp_rdata); end
    reset = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (i0.req_ready !== 1'b1 || i1.req_ready !== 1'b1)
      begin errors++; $display("FAIL reset_ready: got %b/%b expected 1/1", i0.req_ready, i1.req_ready); end
    @(negedge clock);
  endtask

  task automatic test_write;
    int n;
    i0.req_valid = 1'b1; i0.req_write = 1'b1;
    i0.req_addr = 32'h0000_1000; i0.req_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    i0.req_valid = 1'b0;
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write, i0.req_ready} !== 5'b11010 || i0.ad_out !== 32'h0000_1000)
      begin errors++; $display("FAIL write_addr: ctl=%b out=%h expected 11010 00001000",
        {i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write, i0.req_ready}, i0.ad_out); end
    @(negedge clock);
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write} !== 4'b1111 || i0.ad_out !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL write_data: ctl=%b out=%h expected 1111 deadbeef",
        {i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write}, i0.ad_out); end
    i0.bus_ack = 1'b1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i0.resp_valid === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 3) begin errors++; $display("FAIL write_ack_latency: got %0d expected 3", n); end
    checks++;
    if ({i0.resp_error, i0.ad_oe, i0.bus_as, i0.bus_ds} !== 4'b0000)
      begin errors++; $display("FAIL write_release: got %b expected 0000",
        {i0.resp_error, i0.ad_oe, i0.bus_as, i0.bus_ds}); end
    i0.bus_ack = 1'b0;
    @(negedge clock);
    checks++;
    if (i0.resp_valid !== 1'b0) begin errors++; $display("FAIL write_pulse: resp_valid=%b expected 0", i0.resp_valid); end
    wait_idle0(n);
    checks++;
    if (n < 1) begin errors++; $display("FAIL write_idle: got %0d expected >=1", n); end
  endtask

  task automatic test_read;
    int  n;
    logic oe_seen;
    i0.req_valid = 1'b1; i0.req_write = 1'b0; i0.req_addr = 32'h0000_2000;
    @(negedge clock);
    i0.req_valid = 1'b0;
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write} !== 4'b1100 || i0.ad_out !== 32'h0000_2000)
      begin errors++; $display("FAIL read_addr: ctl=%b out=%h expected 1100 00002000",
        {i0.ad_oe, i0.bus_as, i0.bus_ds, i0.bus_write}, i0.ad_out); end
    @(negedge clock);
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds} !== 3'b010)
      begin errors++; $display("FAIL read_turn: got %b expected 010", {i0.ad_oe, i0.bus_as, i0.bus_ds}); end
    @(negedge clock);
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds} !== 3'b011)
      begin errors++; $display("FAIL read_data: got %b expected 011", {i0.ad_oe, i0.bus_as, i0.bus_ds}); end
    i0.ad_in = 32'h1234_5678; i0.bus_ack = 1'b1;
    n = -1; oe_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      oe_seen = oe_seen | i0.ad_oe;
      if (i0.resp_valid === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 3 || oe_seen !== 1'b0)
      begin errors++; $display("FAIL read_ack: latency=%0d oe_seen=%b expected 3 0", n, oe_seen); end
    checks++;
    if (i0.resp_rdata !== 32'h1234_5678 || i0.resp_error !== 1'b0)
      begin errors++; $display("FAIL read_rdata: got %h err=%b expected 12345678 0", i0.resp_rdata, i0.resp_error); end
    i0.bus_ack = 1'b0;
    wait_idle0(n);
    checks++;
    if (n < 1) begin errors++; $display("FAIL read_idle: got %0d expected >=1", n); end
  endtask

  task automatic test_timeout;
    int nds, n;
    i0.ad_in = 32'hFFFF_0000;
    i0.req_valid = 1'b1; i0.req_write = 1'b0; i0.req_addr = 32'h0000_2004;
    nds = 0; n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      i0.req_valid = 1'b0;
      if (i0.bus_ds === 1'b1) nds++;
      if (i0.resp_valid === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n < 0 || nds != 8) begin errors++; $display("FAIL timeout_cycles: got %0d data cycles expected 8", nds); end
    checks++;
    if (i0.resp_error !== 1'b1 || i0.resp_rdata !== 32'h1234_5678)
      begin errors++; $display("FAIL timeout_resp: err=%b rdata=%h expected 1 12345678", i0.resp_error, i0.resp_rdata); end
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds} !== 3'b000)
      begin errors++; $display("FAIL timeout_strobes: got %b expected 000", {i0.ad_oe, i0.bus_as, i0.bus_ds}); end
    wait_idle0(n);
    checks++;
    if (n < 1) begin errors++; $display("FAIL timeout_idle: got %0d expected >=1", n); end
  endtask

  task automatic test_ack_held;
    int nds, n, bad;
    i0.bus_ack = 1'b1;
    repeat (3) @(negedge clock);
    i0.req_valid = 1'b1; i0.req_write = 1'b1;
    i0.req_addr = 32'h0000_3000; i0.req_wdata = 32'h55AA_55AA;
    nds = 0; n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i0.bus_ds === 1'b1) nds++;
      if (i0.resp_valid === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n != 3 || nds != 1)
      begin errors++; $display("FAIL early_ack: latency=%0d data_cycles=%0d expected 3 1", n, nds); end
    bad = 0;
    repeat (5) begin
      @(negedge clock);
      if (i0.req_ready !== 1'b0 || i0.bus_as !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL ack_held_release: %0d cycles left RELEASE expected 0", bad); end
    i0.bus_ack = 1'b0;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i0.bus_as === 1'b1) begin n = i; break; end
    end
    i0.req_valid = 1'b0;
    checks++;
    if (n < 0 || i0.ad_out !== 32'h0000_3000)
      begin errors++; $display("FAIL held_req_accept: wait=%0d out=%h expected 00003000", n, i0.ad_out); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (i0.bus_ds === 1'b1) break;
    end
    i0.bus_ack = 1'b1;
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (i0.resp_valid === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n < 0 || i0.resp_error !== 1'b0)
      begin errors++; $display("FAIL held_req_resp: wait=%0d err=%b expected ok 0", n, i0.resp_error); end
    i0.bus_ack = 1'b0;
    wait_idle0(n);
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    i0.req_valid = 1'b1; i0.req_write = 1'b1;
    i0.req_addr = 32'h0000_4000; i0.req_wdata = 32'h1111_2222;
    @(negedge clock);
    i0.req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (i0.bus_ds !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: ds=%b expected 1", i0.bus_ds); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({i0.ad_oe, i0.bus_as, i0.bus_ds, i0.resp_valid} !== 4'b0000)
      begin errors++; $display("FAIL rst_mid_async: got %b expected 0000",
        {i0.ad_oe, i0.bus_as, i0.bus_ds, i0.resp_valid}); end
    rv_seen = 0;
    repeat (3) begin
      @(negedge clock);
      if (i0.resp_valid !== 1'b0) rv_seen++;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (i0.resp_valid !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen != 0 || i0.req_ready !== 1'b1 || i0.bus_as !== 1'b0)
      begin errors++; $display("FAIL rst_mid_after: rv=%0d ready=%b as=%b expected 0 1 0",
        rv_seen, i0.req_ready, i0.bus_as); end
  endtask

  task automatic test_back_to_back;
    logic        oe_t[80], as_t[80], ds_t[80], rv_t[80], rdy_t[80], err_t[80];
    logic [31:0] out_t[80], rd_t[80];
    int last, nrv, a_rd, a_wr, turn, r1, w0, rel, oe_bad;
    logic acc1;
    i1.req_valid = 1'b1; i1.req_write = 1'b0; i1.req_addr = 32'h0000_3000;
    acc1 = 1'b0; nrv = 0; last = 79;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      oe_t[c] = i1.ad_oe; as_t[c] = i1.bus_as; ds_t[c] = i1.bus_ds;
      rv_t[c] = i1.resp_valid; rdy_t[c] = i1.req_ready; err_t[c] = i1.resp_error;
      out_t[c] = i1.ad_out; rd_t[c] = i1.resp_rdata;
      if (i1.bus_as && i1.ad_out == 32'h0000_3000 && !acc1) begin
        acc1 = 1'b1;
        i1.req_write = 1'b1; i1.req_addr = 32'h0000_4000; i1.req_wdata = 32'hCAFE_F00D;
      end
      if (i1.bus_as && i1.ad_out == 32'h0000_4000) i1.req_valid = 1'b0;
      if (i1.bus_ds) begin
        i1.bus_ack = 1'b1;
        if (!i1.bus_write) i1.ad_in = 32'h0BAD_F00D;
      end
      if (i1.resp_valid) begin
        i1.bus_ack = 1'b0;
        nrv++;
        if (nrv == 2) begin last = c; break; end
      end
    end
    checks++;
    if (nrv != 2) begin errors++; $display("FAIL b2b_responses: got %0d expected 2", nrv); end
    a_rd = 0; a_wr = 0; turn = 0; r1 = -1; w0 = -1;
    for (int c = 0; c <= last; c++) begin
      if (as_t[c] && oe_t[c] && !ds_t[c] && out_t[c] == 32'h0000_3000) a_rd++;
      if (as_t[c] && oe_t[c] && !ds_t[c] && out_t[c] == 32'h0000_4000) a_wr++;
      if (as_t[c] && !oe_t[c] && !ds_t[c]) turn++;
      if (rv_t[c] && r1 < 0) r1 = c;
      if (as_t[c] && out_t[c] == 32'h0000_4000 && w0 < 0) w0 = c;
    end
    checks++;
    if (a_rd != 3 || a_wr != 3)
      begin errors++; $display("FAIL b2b_addr_cycles: read=%0d write=%0d expected 3 3", a_rd, a_wr); end
    checks++;
    if (turn != 2) begin errors++; $display("FAIL b2b_turn: got %0d expected 2", turn); end
    checks++;
    if (r1 < 0 || rd_t[r1 < 0 ? 0 : r1] !== 32'h0BAD_F00D || err_t[r1 < 0 ? 0 : r1] !== 1'b0)
      begin errors++; $display("FAIL b2b_rdata: idx=%0d expected rdata 0badf00d err 0", r1); end
    rel = 0; oe_bad = 0;
    if (r1 >= 0 && w0 > r1) begin
      for (int c = r1; c < w0; c++) begin
        if (oe_t[c] !== 1'b0) oe_bad++;
        if (!as_t[c] && !rdy_t[c]) rel++;
      end
    end
    checks++;
    if (w0 - r1 < 2 || oe_bad != 0 || r1 < 0)
      begin errors++; $display("FAIL b2b_oe_gap: gap=%0d oe_on=%0d expected >=2 0", w0 - r1, oe_bad); end
    checks++;
    if (rel < 2) begin errors++; $display("FAIL b2b_release: got %0d expected >=2", rel); end
    checks++;
    if (err_t[last] !== 1'b0 || rv_t[last] !== 1'b1)
      begin errors++; $display("FAIL b2b_write_resp: rv=%b err=%b expected 1 0", rv_t[last], err_t[last]); end
  endtask

  initial begin
    i0.req_valid = 1'b0; i0.req_write = 1'b0; i0.req_addr = '0; i0.req_wdata = '0;
    i0.ad_in = '0; i0.bus_ack = 1'b0;
    i1.req_valid = 1'b0; i1.req_write = 1'b0; i1.req_addr = '0; i1.req_wdata = '0;
    i1.ad_in = '0; i1.bus_ack = 1'b0;
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_ack_held;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
